// File: rtl/mem_dump_uart.sv
// Walks a byte range of the data memory dump port and prints it as uppercase hex
// text (space separated, CR LF every BYTES_PER_LINE bytes) on an 8N1 UART line.
module mem_dump_uart #(
   parameter int CLKS_PER_BIT   = 868,
   parameter int BYTES_PER_LINE = 16,
   parameter int ADDR_W         = 12
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W-1:0] end_addr_i,
   output logic [ADDR_W-1:0] dump_addr_o,
   input  logic [7:0]        dump_data_i,
   output logic              uart_tx_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int LINE_W = $clog2(BYTES_PER_LINE + 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(BYTES_PER_LINE);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      TX_HI  = 3'd2,
      TX_LO  = 3'd3,
      TX_SEP = 3'd4,
      TX_CR  = 3'd5,
      TX_LF  = 3'd6,
      FIN    = 3'd7
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     remain_q;
   logic [LINE_W-1:0]   line_q;
   logic [7:0]          byte_q;
   logic                sent_q;
   logic                busy_q;
   logic                done_q;

   logic                tx_act_q;
   logic [3:0]          tx_bit_q;
   logic [CNT_W-1:0]    tx_cnt_q;
   logic [9:0]          tx_shift_q;
   logic                tx_q;

   logic [ADDR_W-1:0]   span_d;
   logic [ADDR_W:0]     count_d;
   logic [ADDR_W:0]     remain_dec_d;
   logic [LINE_W-1:0]   line_inc_d;
   logic                tx_state_d;
   logic                tx_start_d;
   logic                tx_last_d;
   logic                char_done_d;
   logic [7:0]          tx_char_d;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end else begin
         return 8'h37 + {4'h0, nib};
      end
   endfunction

   assign span_d       = end_addr_i - start_addr_i;
   assign count_d      = {1'b0, span_d} + {{ADDR_W{1'b0}}, 1'b1};
   assign remain_dec_d = remain_q - {{ADDR_W{1'b0}}, 1'b1};
   assign line_inc_d   = line_q + LINE_W'(1);

   assign tx_state_d  = (state_q == TX_HI) || (state_q == TX_LO) || (state_q == TX_SEP) ||
                        (state_q == TX_CR) || (state_q == TX_LF);
   // A character is handed to the transmitter once per TX_* visit; sent_q blocks a resend.
   assign tx_start_d  = tx_state_d && !sent_q && !tx_act_q;
   assign tx_last_d   = tx_act_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BIT_LAST);
   assign char_done_d = sent_q && tx_last_d;

   // Character selected by the current output state
   always_comb begin
      tx_char_d = 8'h00;
      case (state_q)
         TX_HI:   tx_char_d = hex_ascii(byte_q[7:4]);
         TX_LO:   tx_char_d = hex_ascii(byte_q[3:0]);
         TX_SEP:  tx_char_d = 8'h20;
         TX_CR:   tx_char_d = 8'h0D;
         TX_LF:   tx_char_d = 8'h0A;
         default: tx_char_d = 8'h00;
      endcase
   end

   // Dump sequencer: address walk, byte capture, line formatting and status outputs
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         line_q   <= '0;
         byte_q   <= 8'h00;
         sent_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (tx_start_d) begin
            sent_q <= 1'b1;
         end else if (char_done_d) begin
            sent_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  addr_q   <= start_addr_i;
                  remain_q <= count_d;
                  line_q   <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= FETCH;
               end
            end
            FETCH: begin
               byte_q  <= dump_data_i;
               state_q <= TX_HI;
            end
            TX_HI: begin
               if (char_done_d) begin
                  state_q <= TX_LO;
               end
            end
            TX_LO: begin
               if (char_done_d) begin
                  remain_q <= remain_dec_d;
                  if ((remain_dec_d == '0) || (line_inc_d == LINE_FULL)) begin
                     line_q  <= '0;
                     state_q <= TX_CR;
                  end else begin
                     line_q  <= line_inc_d;
                     state_q <= TX_SEP;
                  end
               end
            end
            TX_SEP: begin
               if (char_done_d) begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  state_q <= FETCH;
               end
            end
            TX_CR: begin
               if (char_done_d) begin
                  state_q <= TX_LF;
               end
            end
            TX_LF: begin
               if (char_done_d) begin
                  if (remain_q != '0) begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     state_q <= FETCH;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end
               end
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // 8N1 shifter: the shift register holds {stop, data, start}; bit 0 is on the line
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         tx_act_q   <= 1'b0;
         tx_bit_q   <= 4'd0;
         tx_cnt_q   <= '0;
         tx_shift_q <= 10'h3FF;
         tx_q       <= 1'b1;
      end else if (tx_start_d) begin
         tx_act_q   <= 1'b1;
         tx_bit_q   <= 4'd0;
         tx_cnt_q   <= '0;
         tx_shift_q <= {1'b1, tx_char_d, 1'b0};
         tx_q       <= 1'b0;
      end else if (tx_act_q) begin
         if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
               tx_act_q <= 1'b0;
            end else begin
               tx_bit_q   <= tx_bit_q + 4'd1;
               tx_shift_q <= {1'b1, tx_shift_q[9:1]};
               tx_q       <= tx_shift_q[1];
            end
         end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
         end
      end else begin
         tx_q <= 1'b1;
      end
   end

   assign dump_addr_o = addr_q;
   assign uart_tx_o   = tx_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
